// File: rtl/zeroheti_pkg.sv
// Shared types for the zeroheti interrupt taker.
// Macro ZEROHETI_SHV_EN adds the vector-table fetch states.
package zeroheti_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_DONE  = 3'd2
`ifdef ZEROHETI_SHV_EN
    ,
    ST_FETCH = 3'd3,
    ST_WAIT  = 3'd4
`endif
  } irq_taker_state_e;

  typedef struct packed {
    logic [15:0] num_irqs;
    logic [7:0]  num_prio;
    logic [7:0]  nest_depth;
  } core_cfg_t;

  // Byte offset of a 32-bit table/jump entry.
  function automatic logic [31:0] word_offset(input logic [31:0] idx);
    return {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/zeroheti_level_stack.sv
// LIFO of previous interrupt levels; a simultaneous push and pop cancel out.
module zeroheti_level_stack #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned IdxW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  wr_idx_s, rd_idx_s;

  assign full_o   = (cnt_q == CntW'(Depth));
  assign empty_o  = (cnt_q == '0);
  assign wr_idx_s = IdxW'(cnt_q);
  assign rd_idx_s = IdxW'(cnt_q - CntW'(1));
  assign top_o    = empty_o ? '0 : mem_q[rd_idx_s];

  // Next-state: push/pop with overflow and underflow ignored.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push_i && pop_i) begin
      cnt_d = cnt_q;
    end else if (push_i && !full_o) begin
      mem_d[wr_idx_s] = data_i;
      cnt_d = cnt_q + CntW'(1);
    end else if (pop_i && !empty_o) begin
      cnt_d = cnt_q - CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/zeroheti_irq_taker.sv
// Core-side interrupt responder: arbitration, trap request, handler address, nesting levels.
// ZEROHETI_SHV_EN enables selective hardware vectoring through the vt_* table port.
module zeroheti_irq_taker
  import zeroheti_pkg::*;
#(
  parameter  int unsigned NumIrqs   = 64,
  parameter  int unsigned NumPrio   = 8,
  parameter  int unsigned NestDepth = 4,
  localparam int unsigned IrqWidth  = $clog2(NumIrqs),
  localparam int unsigned PrioWidth = $clog2(NumPrio)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 irq_valid_i,
  input  logic [IrqWidth-1:0]  irq_id_i,
  input  logic [PrioWidth-1:0] irq_level_i,
  input  logic [1:0]           irq_priv_i,
  input  logic                 irq_shv_i,
  input  logic                 irq_nest_i,
  output logic                 irq_ack_o,
  output logic [IrqWidth-1:0]  irq_id_o,
  input  logic                 mie_i,
  input  logic [PrioWidth-1:0] thresh_i,
  input  logic [31:0]          mtvec_i,
  input  logic [31:0]          mtvt_i,
  output logic                 trap_req_o,
  input  logic                 trap_ack_i,
  output logic [31:0]          trap_pc_o,
  output logic                 trap_valid_o,
  output logic [IrqWidth-1:0]  trap_cause_o,
  output logic [1:0]           trap_priv_o,
  input  logic                 mret_i,
  output logic [PrioWidth-1:0] level_o,
  output logic                 vt_req_o,
  output logic [31:0]          vt_addr_o,
  input  logic                 vt_gnt_i,
  input  logic                 vt_rvalid_i,
  input  logic                 vt_err_i,
  input  logic [31:0]          vt_rdata_i,
  output logic                 vt_err_o
);

  irq_taker_state_e     state_q, state_d;
  logic [IrqWidth-1:0]  id_q, id_d;
  logic [PrioWidth-1:0] lvl_q, lvl_d;
  logic [PrioWidth-1:0] level_q, level_d;
  logic [1:0]           priv_q, priv_d;
  logic [31:0]          pc_q, pc_d;
  logic [PrioWidth-1:0] eff_thr_s, stk_top_s;
  logic                 take_s, push_s, pop_s, stk_full_s, stk_empty_s;
`ifdef ZEROHETI_SHV_EN
  logic                 shv_q, shv_d;
  logic                 err_q, err_d;
`else
  logic                 unused_shv_s;
`endif

  zeroheti_level_stack #(
    .Depth (NestDepth),
    .Width (PrioWidth)
  ) u_level_stack (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (level_q),
    .top_o   (stk_top_s),
    .full_o  (stk_full_s),
    .empty_o (stk_empty_s)
  );

  // Must beat both the running level and the threshold; never evaluated alongside mret.
  assign eff_thr_s = (level_q > thresh_i) ? level_q : thresh_i;
  assign take_s    = irq_valid_i & mie_i & (irq_level_i > eff_thr_s)
                   & (stk_empty_s | irq_nest_i) & ~stk_full_s & ~mret_i;

  // Handshake FSM, handler address resolution and level bookkeeping.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    lvl_d   = lvl_q;
    priv_d  = priv_q;
    pc_d    = pc_q;
    level_d = level_q;
    push_s  = 1'b0;
    pop_s   = 1'b0;
`ifdef ZEROHETI_SHV_EN
    shv_d   = shv_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          state_d = ST_REQ;
          id_d    = irq_id_i;
          lvl_d   = irq_level_i;
          priv_d  = irq_priv_i;
`ifdef ZEROHETI_SHV_EN
          shv_d   = irq_shv_i;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (trap_ack_i) begin
`ifdef ZEROHETI_SHV_EN
          if (shv_q) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
            pc_d    = mtvec_i;
          end
`else
          state_d = ST_DONE;
          pc_d    = mtvec_i + word_offset(32'(id_q));
`endif
        end else begin
          state_d = ST_REQ;
        end
      end
`ifdef ZEROHETI_SHV_EN
      ST_FETCH: begin
        if (vt_gnt_i) state_d = ST_WAIT;
        else          state_d = ST_FETCH;
      end
      ST_WAIT: begin
        if (vt_rvalid_i) begin
          state_d = ST_DONE;
          if (vt_err_i) begin
            pc_d  = mtvec_i;
            err_d = 1'b1;
          end else begin
            pc_d  = vt_rdata_i & ~32'd1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
        push_s  = 1'b1;
        level_d = lvl_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // mret in the DONE cycle undoes the push, leaving the level where it was.
    if (mret_i) begin
      pop_s = 1'b1;
      if (state_q == ST_DONE) level_d = level_q;
      else if (stk_empty_s)   level_d = '0;
      else                    level_d = stk_top_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // State and latched request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      lvl_q   <= '0;
      priv_q  <= 2'b00;
      pc_q    <= 32'd0;
      level_q <= '0;
`ifdef ZEROHETI_SHV_EN
      shv_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      lvl_q   <= lvl_d;
      priv_q  <= priv_d;
      pc_q    <= pc_d;
      level_q <= level_d;
`ifdef ZEROHETI_SHV_EN
      shv_q   <= shv_d;
      err_q   <= err_d;
`endif
    end
  end

  assign trap_req_o   = (state_q == ST_REQ);
  assign trap_valid_o = (state_q == ST_DONE);
  assign irq_ack_o    = (state_q == ST_DONE);
  assign irq_id_o     = id_q;
  assign trap_cause_o = id_q;
  assign trap_priv_o  = priv_q;
  assign trap_pc_o    = pc_q;
  assign level_o      = level_q;

`ifdef ZEROHETI_SHV_EN
  assign vt_req_o  = (state_q == ST_FETCH);
  assign vt_addr_o = (state_q == ST_FETCH) ? (mtvt_i + word_offset(32'(id_q))) : 32'd0;
  assign vt_err_o  = err_q;
`else
  assign vt_req_o     = 1'b0;
  assign vt_addr_o    = 32'd0;
  assign vt_err_o     = 1'b0;
  assign unused_shv_s = ^{irq_shv_i, mtvt_i, vt_gnt_i, vt_rvalid_i, vt_err_i, vt_rdata_i};
`endif

endmodule
